// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

   localparam int unsigned INSTR_W = 12;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 12'h000;
   localparam logic [3:0] HALT_OPCODE = 4'hF;

   typedef enum logic [1:0] {FILL, RUN, HALT} fetch_state_t;

endpackage

// File: rtl/fetch_sat_counter.sv
// 16-bit saturating event counter with enable and synchronous clear.
module fetch_sat_counter (
   input  logic        clk,
   input  logic        clear,
   input  logic        enable,
   output logic [15:0] count
);

   logic [15:0] count_q;

   always_ff @(posedge clk) begin
      if (clear) begin
         count_q <= 16'h0000;
      end else if (enable && (count_q != 16'hFFFF)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives a synchronous-read instruction memory and delivers one
// instruction per cycle to IF/ID, with stall, redirect and HALT handling.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned           PC_W     = 8,
   parameter logic [PC_W-1:0]       RESET_PC = '0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               stop,
   input  logic               branch_taken,
   input  logic [PC_W-1:0]    branch_target,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instruction_out,
   output logic [PC_W-1:0]    pc_out,
   output logic               valid_out,
   output logic               halted,
   output logic [15:0]        fetch_count
);

   localparam logic [PC_W-1:0] PC_ONE = 1;

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] pc_inc;
   logic            halt_op;

   // pc_q is the address whose data is currently on imem_rdata
   assign pc_inc  = pc_q + PC_ONE;
   assign halt_op = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FILL;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (branch_taken) begin
         state_d = FILL;
         pc_d    = branch_target;
      end else begin
         case (state_q)
            FILL: state_d = RUN;
            RUN: begin
               if (!stop) begin
                  pc_d = pc_inc;
                  if (halt_op) state_d = HALT;
               end
            end
            HALT:    state_d = HALT;
            default: state_d = FILL;
         endcase
      end
   end

   always_comb begin
      imem_addr       = pc_q;
      valid_out       = 1'b0;
      instruction_out = NOP_INSTR;
      halted          = 1'b0;
      case (state_q)
         RUN: begin
            valid_out       = 1'b1;
            instruction_out = imem_rdata;
            // Stalled: re-read the same address so the held output stays valid
            if (!stop) imem_addr = pc_inc;
         end
         HALT:    halted = 1'b1;
         default: ;
      endcase
   end

   assign pc_out = pc_q;

   fetch_sat_counter u_fetch_count (
      .clk    (clk),
      .clear  (reset),
      .enable ((state_q == RUN) && !stop),
      .count  (fetch_count)
   );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a behavioural synchronous ROM.
module tb_instruction_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stop = 1'b0;
   logic        branch_taken = 1'b0;
   logic [7:0]  branch_target = 8'h00;
   logic [7:0]  imem_addr;
   logic [11:0] imem_rdata;
   logic [11:0] instruction_out;
   logic [7:0]  pc_out;
   logic        valid_out;
   logic        halted;
   logic [15:0] fetch_count;

   logic [11:0] mem [256];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) imem_rdata <= mem[imem_addr];

   instruction_fetch_unit dut (
      .clk             (clk),
      .reset           (reset),
      .stop            (stop),
      .branch_taken    (branch_taken),
      .branch_target   (branch_target),
      .imem_addr       (imem_addr),
      .imem_rdata      (imem_rdata),
      .instruction_out (instruction_out),
      .pc_out          (pc_out),
      .valid_out       (valid_out),
      .halted          (halted),
      .fetch_count     (fetch_count)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL rst_valid got %h want 0", valid_out); end
      checks++; if (instruction_out !== 12'h000) begin errors++; $display("FAIL rst_instr got %h want 000", instruction_out); end
      checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL rst_pc got %h want 00", pc_out); end
      checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h want 00", imem_addr); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %h want 0", halted); end
      checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL rst_count got %h want 0000", fetch_count); end
   endtask

   task automatic test_startup();
      reset = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL start_c1_valid got %h want 0", valid_out); end
      step();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("FAIL start_c2_valid got %h want 1", valid_out); end
      checks++; if (instruction_out !== 12'h100) begin errors++; $display("FAIL start_c2_instr got %h want 100", instruction_out); end
      checks++; if (pc_out !== 8'h00) begin errors++; $display("FAIL start_c2_pc got %h want 00", pc_out); end
      step();
      checks++; if (instruction_out !== 12'h101) begin errors++; $display("FAIL start_c3_instr got %h want 101", instruction_out); end
      checks++; if (pc_out !== 8'h01) begin errors++; $display("FAIL start_c3_pc got %h want 01", pc_out); end
      step();
      checks++; if (fetch_count !== 16'd2) begin errors++; $display("FAIL start_count got %0d want 2", fetch_count); end
   endtask

   task automatic test_stall();
      // Arrive at pc 5 with five deliveries so far
      step(); step(); step();
      checks++; if (pc_out !== 8'h05) begin errors++; $display("FAIL stall_entry_pc got %h want 05", pc_out); end
      stop = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (instruction_out !== 12'h105) begin errors++; $display("FAIL stall_instr[%0d] got %h want 105", i, instruction_out); end
         checks++; if (pc_out !== 8'h05 || valid_out !== 1'b1) begin errors++; $display("FAIL stall_pc[%0d] got %h/%h want 05/1", i, pc_out, valid_out); end
         checks++; if (fetch_count !== 16'd5) begin errors++; $display("FAIL stall_count[%0d] got %0d want 5", i, fetch_count); end
         checks++; if (imem_addr !== 8'h05) begin errors++; $display("FAIL stall_addr[%0d] got %h want 05", i, imem_addr); end
         step();
      end
      stop = 1'b0;
      #1;
      checks++; if (pc_out !== 8'h05 || instruction_out !== 12'h105) begin errors++; $display("FAIL release_pc got %h/%h want 05/105", pc_out, instruction_out); end
      step();
      checks++; if (pc_out !== 8'h06) begin errors++; $display("FAIL after_release_pc got %h want 06", pc_out); end
      checks++; if (fetch_count !== 16'd6) begin errors++; $display("FAIL after_release_count got %0d want 6", fetch_count); end
   endtask

   task automatic test_branch();
      step(); step(); step(); step();
      checks++; if (pc_out !== 8'h0A) begin errors++; $display("FAIL br_entry_pc got %h want 0a", pc_out); end
      branch_taken = 1'b1;
      branch_target = 8'h40;
      #1;
      checks++; if (instruction_out !== 12'h10A || valid_out !== 1'b1) begin errors++; $display("FAIL br_cycle_out got %h/%h want 10a/1", instruction_out, valid_out); end
      step();
      branch_taken = 1'b0;
      checks++; if (valid_out !== 1'b0 || instruction_out !== 12'h000) begin errors++; $display("FAIL br_bubble got %h/%h want 0/000", valid_out, instruction_out); end
      step();
      checks++; if (pc_out !== 8'h40 || instruction_out !== 12'h140) begin errors++; $display("FAIL br_target got %h/%h want 40/140", pc_out, instruction_out); end
      checks++; if (fetch_count !== 16'd11) begin errors++; $display("FAIL br_count got %0d want 11", fetch_count); end
      // Redirect wins over a simultaneous stall
      stop = 1'b1;
      branch_taken = 1'b1;
      branch_target = 8'h60;
      step();
      branch_taken = 1'b0;
      stop = 1'b0;
      checks++; if (valid_out !== 1'b0 || pc_out !== 8'h60) begin errors++; $display("FAIL br_stall_bubble got %h/%h want 0/60", valid_out, pc_out); end
      step();
      checks++; if (instruction_out !== 12'h160 || valid_out !== 1'b1) begin errors++; $display("FAIL br_stall_target got %h/%h want 160/1", instruction_out, valid_out); end
      checks++; if (fetch_count !== 16'd11) begin errors++; $display("FAIL br_stall_count got %0d want 11", fetch_count); end
   endtask

   task automatic test_wrap();
      branch_taken = 1'b1;
      branch_target = 8'hFE;
      step();
      branch_taken = 1'b0;
      step();
      checks++; if (pc_out !== 8'hFE || instruction_out !== 12'h1FE) begin errors++; $display("FAIL wrap_fe got %h/%h want fe/1fe", pc_out, instruction_out); end
      step();
      checks++; if (pc_out !== 8'hFF || instruction_out !== 12'h1FF) begin errors++; $display("FAIL wrap_ff got %h/%h want ff/1ff", pc_out, instruction_out); end
      step();
      checks++; if (pc_out !== 8'h00 || instruction_out !== 12'h100 || valid_out !== 1'b1) begin errors++; $display("FAIL wrap_00 got %h/%h/%h want 00/100/1", pc_out, instruction_out, valid_out); end
   endtask

   task automatic test_halt();
      mem[3] = 12'hF00;
      reset = 1'b1;
      step();
      reset = 1'b0;
      step(); step(); step(); step();
      checks++; if (instruction_out !== 12'hF00 || valid_out !== 1'b1 || pc_out !== 8'h03) begin errors++; $display("FAIL halt_deliver got %h/%h/%h want f00/1/03", instruction_out, valid_out, pc_out); end
      step();
      checks++; if (halted !== 1'b1 || valid_out !== 1'b0 || instruction_out !== 12'h000) begin errors++; $display("FAIL halt_enter got %h/%h/%h want 1/0/000", halted, valid_out, instruction_out); end
      checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL halt_count got %0d want 4", fetch_count); end
      stop = 1'b1;
      step(); step();
      stop = 1'b0;
      step();
      checks++; if (halted !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL halt_stay got %h/%h want 1/0", halted, valid_out); end
      checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL halt_stay_count got %0d want 4", fetch_count); end
      branch_taken = 1'b1;
      branch_target = 8'h20;
      step();
      branch_taken = 1'b0;
      checks++; if (halted !== 1'b0 || valid_out !== 1'b0 || pc_out !== 8'h20) begin errors++; $display("FAIL halt_exit_fill got %h/%h/%h want 0/0/20", halted, valid_out, pc_out); end
      step();
      checks++; if (instruction_out !== 12'h120 || valid_out !== 1'b1) begin errors++; $display("FAIL halt_exit_run got %h/%h want 120/1", instruction_out, valid_out); end
      mem[3] = 12'h103;
   endtask

   task automatic test_reset_during_stall();
      stop = 1'b1;
      reset = 1'b1;
      step();
      checks++; if (valid_out !== 1'b0 || instruction_out !== 12'h000 || halted !== 1'b0) begin errors++; $display("FAIL rst_stall_out got %h/%h/%h want 0/000/0", valid_out, instruction_out, halted); end
      checks++; if (pc_out !== 8'h00 || imem_addr !== 8'h00) begin errors++; $display("FAIL rst_stall_pc got %h/%h want 00/00", pc_out, imem_addr); end
      checks++; if (fetch_count !== 16'h0000) begin errors++; $display("FAIL rst_stall_count got %h want 0000", fetch_count); end
      stop = 1'b0;
   endtask

   task automatic test_saturation();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      // Now in the first delivering cycle with a zero count
      for (int i = 0; i < 65534; i++) step();
      checks++; if (fetch_count !== 16'hFFFE) begin errors++; $display("FAIL sat_preset got %h want fffe", fetch_count); end
      step(); step(); step();
      checks++; if (fetch_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", fetch_count); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 12'(12'h100 + i);
      test_reset();
      test_startup();
      test_stall();
      test_branch();
      test_wrap();
      test_halt();
      test_reset_during_stall();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter PC_W, 8, instruction-memory address width in bits.
REQ-002 Parameter RESET_PC, 0, first fetch address after reset.
REQ-003 clk  input  1  system clock; one clock domain, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 stop  input  1  pipeline stall from hazard logic; shared with the IF/ID register.
REQ-006 branch_taken  input  1  redirect request, sampled on the rising clk edge.
REQ-007 branch_target  input  PC_W  redirect address, valid when branch_taken=1.
REQ-008 imem_addr  output  PC_W  synchronous-read instruction memory address; data returns the next cycle.
REQ-009 imem_rdata  input  12  instruction at the imem_addr presented in the previous cycle.
REQ-010 instruction_out  output  12  instruction to IF/ID; 12'h000 (NOP) whenever valid_out=0.
REQ-011 pc_out  output  PC_W  address of instruction_out.
REQ-012 valid_out  output  1  instruction_out carries a real fetched instruction.
REQ-013 halted  output  1  fetch stopped by a HALT instruction.
REQ-014 fetch_count  output  16  saturating count of instructions delivered (valid_out=1 and stop=0).

Function
REQ-015 States: FILL (address issued, no data yet), RUN (delivering instructions), HALT (frozen).
REQ-016 The register pc_q holds the address whose data is on imem_rdata in the current cycle; pc_out=pc_q.
REQ-017 FILL: imem_addr=pc_q, valid_out=0, and the next state is RUN unconditionally unless branch_taken=1.
REQ-018 RUN with stop=0: imem_addr=pc_q+1 mod 2^PC_W, pc_q<=imem_addr, valid_out=1, instruction_out=imem_rdata.
REQ-019 RUN with stop=1: imem_addr=pc_q and pc_q holds, so instruction_out, pc_out and valid_out stay unchanged next cycle.
REQ-020 PC wrap-around: address 2^PC_W-1 is followed by 0 with no bubble.
REQ-021 Redirect: branch_taken=1 in any state -> pc_q<=branch_target, next state FILL; the redirect-cycle output is still delivered and the next cycle is a single bubble (valid_out=0).
REQ-022 Priority, highest first: reset, branch_taken, stop, HALT detection.
REQ-023 HALT detection: in RUN with valid_out=1, stop=0 and imem_rdata[11:8]=4'hF, the HALT instruction is delivered that cycle and the next state is HALT.
REQ-024 HALT: valid_out=0, instruction_out=NOP, halted=1, imem_addr=pc_q; stop has no effect; only reset or branch_taken exits.
REQ-025 fetch_count increments by 1 per delivered instruction and saturates at 16'hFFFF.
REQ-026 Steady-state throughput is one instruction per cycle; redirect penalty is exactly one bubble.

Reset
REQ-027 While reset=1: state=FILL, pc_q=RESET_PC, imem_addr=RESET_PC, valid_out=0, instruction_out=12'h000, pc_out=RESET_PC, halted=0, fetch_count=0.
REQ-028 Reset asserted mid-operation (RUN, stall or HALT) overrides all inputs on that edge; the first valid instruction, mem[RESET_PC], appears in the second cycle after reset deasserts.

Structure
REQ-029 Package fetch_pkg holds INSTR_W=12, NOP_INSTR=12'h000, HALT_OPCODE=4'hF and the state enum fetch_state_t {FILL, RUN, HALT}.
REQ-030 One sub-module, fetch_sat_counter (16-bit, enable, synchronous clear), implements fetch_count; all other logic stays in instruction_fetch_unit.
REQ-031 Outputs are combinational from pc_q, state and imem_rdata; the IF/ID register provides the pipeline boundary.

Verification
REQ-032 Benches use a behavioural synchronous ROM with mem[i]=12'h100+i and the default parameters.
REQ-033 Reset release, stop=0 -> cycle 1 valid_out=0; cycle 2 instruction_out=12'h100, pc_out=0; cycle 3 12'h101, pc_out=1; fetch_count=2 after cycle 3.
REQ-034 stop held 3 cycles while pc_out=5 -> instruction_out=12'h105 and pc_out=5 held for all 3 cycles, fetch_count unchanged; the cycle after release shows pc_out=6.
REQ-035 branch_taken=1, branch_target=8'h40 while pc_out=10 -> one bubble cycle, then pc_out=8'h40, instruction_out=12'h140; branch with stop=1 in the same cycle -> redirect still taken.
REQ-036 pc_q=8'hFF delivered -> next cycle pc_out=8'h00 with no bubble; fetch_count preset to 16'hFFFE and 3 deliveries -> fetch_count=16'hFFFF.
REQ-037 mem[3]=12'hF00 -> delivered once, then halted=1, valid_out=0 indefinitely; branch_target=8'h20 -> FILL, then 12'h120; reset asserted during a stall -> all REQ-027 values on the next cycle.
